// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing MIPS instructions through the
// shared-ALU/shared-memory multicycle datapath. It stalls on memReady_in,
// times out long memory waits, and parks in a sticky ERROR state.
// Optional: define MULTICYCLE_BNE_EN to decode bne (000101) as a branch.
module multicycle_control #(
   parameter int MEM_TIMEOUT   = 15,
   parameter int TIMEOUT_WIDTH = 8
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic [5:0] opcode_in,
   input  logic       memReady_in,
   output logic       pcWrite_out,
   output logic       pcWriteCond_out,
   output logic       branchNe_out,
   output logic       iorD_out,
   output logic       memRead_out,
   output logic       memWrite_out,
   output logic       irWrite_out,
   output logic       memtoReg_out,
   output logic [1:0] pcSource_out,
   output logic [1:0] aluOp_out,
   output logic       aluSrcA_out,
   output logic [1:0] aluSrcB_out,
   output logic       regWrite_out,
   output logic       regDst_out,
   output logic [3:0] state_out,
   output logic       error_out,
   output logic [1:0] errorCause_out
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
      S_BRANCH  = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
      S_ERROR   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDIU = 6'b001001;

   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_V = TIMEOUT_WIDTH'(MEM_TIMEOUT);

   state_t                   state, state_nxt;
   logic [1:0]               cause, cause_nxt;
   logic [TIMEOUT_WIDTH-1:0] wait_cnt;
   logic                     mem_wait, timeout;

   // States that block on the memory handshake, and the expiry of that wait
   assign mem_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign timeout  = mem_wait && !memReady_in && (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_V);

   // State and error-cause registers
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state <= S_FETCH;
         cause <= 2'b00;
      end else begin
         state <= state_nxt;
         cause <= cause_nxt;
      end
   end

   // Wait counter: cleared on every state change, saturating count of stalled cycles
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in)
         wait_cnt <= '0;
      else if (state_nxt != state)
         wait_cnt <= '0;
      else if (mem_wait && !memReady_in && (wait_cnt != '1))
         wait_cnt <= wait_cnt + 1'b1;
   end

`ifdef MULTICYCLE_BNE_EN
   logic bne_q;
   // Remember whether the branch decoded this instruction is bne
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in)
         bne_q <= 1'b0;
      else if (state == S_DECODE)
         bne_q <= (opcode_in == OP_BNE);
   end
`endif

   // Next-state logic; a memory timeout overrides the normal hold
   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      case (state)
         S_FETCH:   if (memReady_in) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode_in)
               OP_RTYPE:     state_nxt = S_EXECUTE;
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
               OP_BNE:       state_nxt = S_BRANCH;
`endif
               OP_J:         state_nxt = S_JUMP;
               OP_ADDIU:     state_nxt = S_ADDIEX;
               default: begin
                  state_nxt = S_ERROR;
                  cause_nxt = 2'b01;
               end
            endcase
         end
         // opcode_in comes from the IR, so it is still valid here
         S_MEMADR:  state_nxt = (opcode_in == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (memReady_in) state_nxt = S_MEMWB;
         S_MEMWB:   state_nxt = S_FETCH;
         S_MEMWR:   if (memReady_in) state_nxt = S_FETCH;
         S_EXECUTE: state_nxt = S_ALUWB;
         S_ALUWB:   state_nxt = S_FETCH;
         S_BRANCH:  state_nxt = S_FETCH;
         S_JUMP:    state_nxt = S_FETCH;
         S_ADDIEX:  state_nxt = S_ADDIWB;
         S_ADDIWB:  state_nxt = S_FETCH;
         S_ERROR:   state_nxt = S_ERROR;
         default:   state_nxt = S_FETCH;
      endcase
      if (timeout) begin
         state_nxt = S_ERROR;
         cause_nxt = 2'b10;
      end
   end

   // Moore outputs from the registered state; reset blanks them immediately
   always_comb begin
      pcWrite_out     = 1'b0;
      pcWriteCond_out = 1'b0;
      branchNe_out    = 1'b0;
      iorD_out        = 1'b0;
      memRead_out     = 1'b0;
      memWrite_out    = 1'b0;
      irWrite_out     = 1'b0;
      memtoReg_out    = 1'b0;
      pcSource_out    = 2'b00;
      aluOp_out       = 2'b00;
      aluSrcA_out     = 1'b0;
      aluSrcB_out     = 2'b00;
      regWrite_out    = 1'b0;
      regDst_out      = 1'b0;
      error_out       = 1'b0;
      if (!reset_in) begin
         case (state)
            S_FETCH: begin
               memRead_out = 1'b1;
               aluSrcB_out = 2'b01;
               irWrite_out = memReady_in;
               pcWrite_out = memReady_in;
            end
            S_DECODE:  aluSrcB_out = 2'b11;
            S_MEMADR: begin
               aluSrcA_out = 1'b1;
               aluSrcB_out = 2'b10;
            end
            S_MEMRD: begin
               memRead_out = 1'b1;
               iorD_out    = 1'b1;
            end
            S_MEMWB: begin
               memtoReg_out = 1'b1;
               regWrite_out = 1'b1;
            end
            S_MEMWR: begin
               memWrite_out = 1'b1;
               iorD_out     = 1'b1;
            end
            S_EXECUTE: begin
               aluSrcA_out = 1'b1;
               aluOp_out   = 2'b10;
            end
            S_ALUWB: begin
               regDst_out   = 1'b1;
               regWrite_out = 1'b1;
            end
            S_BRANCH: begin
               aluSrcA_out     = 1'b1;
               aluOp_out       = 2'b01;
               pcWriteCond_out = 1'b1;
               pcSource_out    = 2'b01;
`ifdef MULTICYCLE_BNE_EN
               branchNe_out    = bne_q;
`endif
            end
            S_JUMP: begin
               pcWrite_out  = 1'b1;
               pcSource_out = 2'b10;
            end
            S_ADDIEX: begin
               aluSrcA_out = 1'b1;
               aluSrcB_out = 2'b10;
            end
            S_ADDIWB:  regWrite_out = 1'b1;
            S_ERROR:   error_out = 1'b1;
            default: ;
         endcase
      end
   end

   assign state_out      = state;
   assign errorCause_out = cause;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle main decoder.
- A registered Moore FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback steps.
- Drives the shared-ALU/shared-memory multicycle datapath and stalls on a memory ready handshake.
- Flags illegal opcodes and memory timeouts through a sticky error state.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles a memory state may wait for memReady_in; 0 disables the timeout.
- TIMEOUT_WIDTH, 8: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- opcode_in  input  6  instr[31:26], taken from the instruction register.
- memReady_in  input  1  memory access completes in this cycle.
- pcWrite_out  output  1  unconditional PC load.
- pcWriteCond_out  output  1  PC load if the branch condition holds.
- branchNe_out  output  1  branch condition is "not zero" (bne).
- iorD_out  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead_out  output  1  memory read strobe.
- memWrite_out  output  1  memory write strobe.
- irWrite_out  output  1  instruction register load.
- memtoReg_out  output  1  writeback select: 1 = MDR.
- pcSource_out  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- aluOp_out  output  2  00 = add, 01 = sub, 10 = use funct.
- aluSrcA_out  output  1  ALU A select: 0 = PC, 1 = rs.
- aluSrcB_out  output  2  ALU B select: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2.
- regWrite_out  output  1  register file write.
- regDst_out  output  1  destination select: 1 = rd.
- state_out  output  4  current state encoding.
- error_out  output  1  FSM is in ERROR.
- errorCause_out  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERROR=15.
- Reset: while reset_in is high, state=FETCH, counter=0, errorCause=00, and every control output is forced 0. Reset asserted mid-instruction aborts it with no further strobes.
- Outputs are decoded from the registered state only, except the FETCH strobes gated by memReady_in. Every output not listed for a state is 0.
- FETCH: memRead=1, aluSrcB=01, irWrite=memReady_in, pcWrite=memReady_in. Advances to DECODE on memReady_in, otherwise holds.
- DECODE: aluSrcB=11. Next state by opcode_in:
  - 000000 -> EXECUTE
  - 100011, 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001001 -> ADDIEX
  - anything else -> ERROR with cause 01
- MEMADR: aluSrcA=1, aluSrcB=10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: memRead=1, iorD=1. Holds until memReady_in, then MEMWB.
- MEMWB: memtoReg=1, regWrite=1, regDst=0. Then FETCH.
- MEMWR: memWrite=1, iorD=1. Holds until memReady_in, then FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Then ALUWB.
- ALUWB: regDst=1, regWrite=1. Then FETCH.
- BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=01. Then FETCH.
- JUMP: pcWrite=1, pcSource=10. Then FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10. Then ADDIWB.
- ADDIWB: regWrite=1, regDst=0. Then FETCH.
- Instruction latency with zero wait states: lw 5, sw/R-type/addiu 4, beq/j 3 cycles.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states with memReady_in low; saturates, no wrap.
  - If the counter equals MEM_TIMEOUT (nonzero) while memReady_in is low, next state is ERROR with cause 10.
  - memReady_in high in that same cycle wins: normal advance, no error.
- ERROR: all control outputs 0, error_out=1. Sticky until reset; errorCause holds its value.

Optional Feature:
- Macro: MULTICYCLE_BNE_EN.
- Defined: DECODE maps 000101 to BRANCH and latches branchNe=1 for that BRANCH cycle; beq drives branchNe=0.
- Undefined: 000101 is illegal (ERROR, cause 01) and branchNe_out is tied 0.

Test Plan:
- Reset asserted mid-MEMRD -> outputs 0 immediately, state_out=0; after release, FETCH with memRead=1.
- lw (100011), memReady_in always 1 -> states 0,1,2,3,4,0; regWrite=1 and memtoReg=1 only in state 4.
- sw, memReady_in held low 3 cycles in MEMWR -> memWrite=1 for 4 cycles, then FETCH, error_out=0.
- R-type, beq, j, addiu back-to-back -> cycle counts 4,3,3,4; pcSource=01 with pcWriteCond=1 for beq, pcSource=10 with pcWrite=1 for j.
- opcode 111111 in DECODE -> ERROR, error_out=1, errorCause=01, held for 20 cycles until reset.
- MEM_TIMEOUT=15, memReady_in held 0 in FETCH -> ERROR with cause 10 after 16 cycles; repeat with memReady_in=1 on the 16th cycle -> DECODE, no error.
